// File: rtl/mul_bisonn_arbiter_pkg.sv
// Shared types and constants for the multiplier / Bisonn arbiter.
//   bisonn_req_t    : one buffered Bisonn request (operands + tag)
//   inflight_slot_t : tracker entry for an op inside the multiplier
//   MUL_BISONN_LAT  : cycles from grant to result on mul_bisonn_valid_i
package mul_bisonn_arbiter_pkg;

    localparam int MUL_BISONN_LAT = 2;

    // Widest tag a Bisonn requester may use; narrower tags are zero-extended
    // on entry and truncated on the way out.
    localparam int BISONN_TAG_MAX_W = 16;

    typedef struct packed {
        logic [63:0]                 rs1;
        logic [63:0]                 rs2;
        logic [BISONN_TAG_MAX_W-1:0] tag;
    } bisonn_req_t;

    typedef struct packed {
        logic valid;
        logic killed;
    } inflight_slot_t;

endpackage

// File: rtl/mul_bisonn_arbiter_req_fifo.sv
// bisonn_req_fifo: Bisonn request buffer with three pointers.
//   wr_ptr  : next free entry (push)
//   iss_ptr : next entry to issue into the multiplier
//   cmt_ptr : oldest entry not yet returned as a response
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i/push_req_i write push_req_i at wr_ptr
//   issue_i           advance iss_ptr
//   commit_i          advance cmt_ptr
//   rewind_i          move iss_ptr back to the post-commit cmt_ptr
//   occupancy_o       wr_ptr - cmt_ptr
//   pending_o         wr_ptr - iss_ptr
//   iss_req_o         entry at iss_ptr
//   cmt_tag_o         tag of entry at cmt_ptr
module bisonn_req_fifo
    import mul_bisonn_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  bisonn_req_t                 push_req_i,
    input  logic                        issue_i,
    input  logic                        commit_i,
    input  logic                        rewind_i,
    output logic [$clog2(DEPTH):0]      occupancy_o,
    output logic [$clog2(DEPTH):0]      pending_o,
    output bisonn_req_t                 iss_req_o,
    output logic [BISONN_TAG_MAX_W-1:0] cmt_tag_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    bisonn_req_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] cmt_ptr;
    logic [PW-1:0] cmt_ptr_next;

    assign cmt_ptr_next = commit_i ? cmt_ptr + PW'(1) : cmt_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            cmt_ptr <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // A rewind restarts issue at the oldest uncommitted entry,
            // accounting for a commit happening in the same cycle.
            if (rewind_i) begin
                iss_ptr <= cmt_ptr_next;
            end else if (issue_i) begin
                iss_ptr <= iss_ptr + PW'(1);
            end
            cmt_ptr <= cmt_ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr[AW-1:0]] <= push_req_i;
        end
    end

    assign occupancy_o = wr_ptr - cmt_ptr;
    assign pending_o   = wr_ptr - iss_ptr;
    assign iss_req_o   = mem[iss_ptr[AW-1:0]];
    assign cmt_tag_o   = mem[cmt_ptr[AW-1:0]].tag;

endmodule

// File: rtl/mul_bisonn_arbiter.sv
// mul_bisonn_arbiter: shares the two-stage execute multiplier between the
// core MUL path and the Bisonn accelerator port.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   Bisonn request channel (valid/ready, operands, tag)
//   resp_*                  in-order Bisonn response, one-cycle pulse
//   core_mul_valid_i        core has a MUL op waiting (not gated by stall)
//   flush_mul_i             pipeline flush also seen by the multiplier
//   core_mul_stall_o        core must hold its MUL op this cycle
//   mul_bisonn_valid_o/rs*  issue side of the multiplier's Bisonn port
//   mul_bisonn_valid_i/rd_i result side of the multiplier's Bisonn port
module mul_bisonn_arbiter
    import mul_bisonn_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int MAX_DEFER  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [63:0]      req_rs1_i,
    input  logic [63:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    output logic [63:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    input  logic             core_mul_valid_i,
    input  logic             flush_mul_i,
    output logic             core_mul_stall_o,
    output logic             mul_bisonn_valid_o,
    output logic [63:0]      mul_bisonn_rs1_o,
    output logic [63:0]      mul_bisonn_rs2_o,
    input  logic             mul_bisonn_valid_i,
    input  logic [63:0]      mul_bisonn_rd_i
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam int P1 = MUL_BISONN_LAT - 1;

    logic [PW-1:0]               occupancy;
    logic [PW-1:0]               pending;
    bisonn_req_t                 push_req;
    bisonn_req_t                 iss_req;
    logic [BISONN_TAG_MAX_W-1:0] cmt_tag;
    logic                        push;
    logic                        grant;
    logic                        commit;
    logic                        rewind;
    logic                        defer_at_max;
    logic [DW-1:0]               defer_cnt;
    inflight_slot_t              slot_q [MUL_BISONN_LAT];

    // Ready depends only on registered pointers, never on this cycle's
    // commit, so there is no combinational path from the multiplier result.
    assign req_ready_o = occupancy < PW'(FIFO_DEPTH);
    assign push        = req_valid_i & req_ready_o;

    assign push_req.rs1 = req_rs1_i;
    assign push_req.rs2 = req_rs2_i;
    assign push_req.tag = BISONN_TAG_MAX_W'(req_tag_i);

    assign defer_at_max = defer_cnt == DW'(MAX_DEFER);

    // Never issue during a flush: the op would be corrupted in stage 0.
    assign grant = (pending != '0) & ~flush_mul_i
                 & (~core_mul_valid_i | defer_at_max);

    assign core_mul_stall_o   = grant & core_mul_valid_i;
    assign mul_bisonn_valid_o = grant;
    assign mul_bisonn_rs1_o   = grant ? iss_req.rs1 : '0;
    assign mul_bisonn_rs2_o   = grant ? iss_req.rs2 : '0;

    // A flush corrupts every op still short of the last multiplier stage;
    // the op in the last stage already has its result registered.
    always_comb begin
        rewind = 1'b0;
        for (int i = 0; i < P1; i++) begin
            if (slot_q[i].valid) begin
                rewind = flush_mul_i;
            end
        end
    end

    // A killed op still produces a multiplier valid; it is dropped here and
    // its entry is reissued from the rewound iss_ptr.
    assign commit       = slot_q[P1].valid & ~slot_q[P1].killed & mul_bisonn_valid_i;
    assign resp_valid_o = commit;
    assign resp_data_o  = commit ? mul_bisonn_rd_i : '0;
    assign resp_tag_o   = commit ? TAG_W'(cmt_tag) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MUL_BISONN_LAT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q[0].valid  <= grant;
            slot_q[0].killed <= 1'b0;
            for (int i = 1; i < MUL_BISONN_LAT; i++) begin
                slot_q[i].valid  <= slot_q[i-1].valid;
                slot_q[i].killed <= slot_q[i-1].killed
                                  | (flush_mul_i & slot_q[i-1].valid);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            defer_cnt <= '0;
        end else if ((pending == '0) || grant) begin
            defer_cnt <= '0;
        end else if (core_mul_valid_i && !defer_at_max) begin
            defer_cnt <= defer_cnt + DW'(1);
        end
    end

    bisonn_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_req_i  (push_req),
        .issue_i     (grant),
        .commit_i    (commit),
        .rewind_i    (rewind),
        .occupancy_o (occupancy),
        .pending_o   (pending),
        .iss_req_o   (iss_req),
        .cmt_tag_o   (cmt_tag)
    );

endmodule

// File: tb/tb_mul_bisonn_arbiter.sv
module tb_mul_bisonn_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_rs1_i;
    logic [63:0] req_rs2_i;
    logic [3:0]  req_tag_i;
    logic        resp_valid_o;
    logic [63:0] resp_data_o;
    logic [3:0]  resp_tag_o;
    logic        core_mul_valid_i;
    logic        flush_mul_i;
    logic        core_mul_stall_o;
    logic        mul_bisonn_valid_o;
    logic [63:0] mul_bisonn_rs1_o;
    logic [63:0] mul_bisonn_rs2_o;
    logic        mul_bisonn_valid_i;
    logic [63:0] mul_bisonn_rd_i;

    mul_bisonn_arbiter #(
        .FIFO_DEPTH (4),
        .TAG_W      (4),
        .MAX_DEFER  (8)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_rs1_i          (req_rs1_i),
        .req_rs2_i          (req_rs2_i),
        .req_tag_i          (req_tag_i),
        .resp_valid_o       (resp_valid_o),
        .resp_data_o        (resp_data_o),
        .resp_tag_o         (resp_tag_o),
        .core_mul_valid_i   (core_mul_valid_i),
        .flush_mul_i        (flush_mul_i),
        .core_mul_stall_o   (core_mul_stall_o),
        .mul_bisonn_valid_o (mul_bisonn_valid_o),
        .mul_bisonn_rs1_o   (mul_bisonn_rs1_o),
        .mul_bisonn_rs2_o   (mul_bisonn_rs2_o),
        .mul_bisonn_valid_i (mul_bisonn_valid_i),
        .mul_bisonn_rd_i    (mul_bisonn_rd_i)
    );

    always #5 clk_i = ~clk_i;

    // Two-stage multiplier model; deliberately ignores flush and reset so
    // stale valids reach the arbiter.
    logic        s0_v = 1'b0;
    logic        s1_v = 1'b0;
    logic [63:0] s0_a = '0;
    logic [63:0] s0_b = '0;
    logic [63:0] s1_p = '0;
    always @(posedge clk_i) begin
        s0_v <= mul_bisonn_valid_o;
        s0_a <= mul_bisonn_rs1_o;
        s0_b <= mul_bisonn_rs2_o;
        s1_v <= s0_v;
        s1_p <= s0_a * s0_b;
    end
    assign mul_bisonn_valid_i = s1_v;
    assign mul_bisonn_rd_i    = s1_p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_stall = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int          edge_n;
        logic [63:0] a;
        logic [63:0] b;
        logic        stall;
    } grant_rec_t;

    typedef struct {
        int          edge_n;
        logic [63:0] data;
        logic [3:0]  tag;
    } resp_rec_t;

    grant_rec_t gq[$];
    resp_rec_t  rq[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Records are stamped with the edge that closes the sampled cycle.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (mul_bisonn_valid_o) begin
                grant_rec_t g;
                g.edge_n = cyc + 1;
                g.a      = mul_bisonn_rs1_o;
                g.b      = mul_bisonn_rs2_o;
                g.stall  = core_mul_stall_o;
                gq.push_back(g);
            end else begin
                chk("ops_zero_idle", {mul_bisonn_rs1_o, mul_bisonn_rs2_o}, 128'd0);
            end
            if (core_mul_stall_o) n_stall++;
            if (flush_mul_i) chk("no_grant_on_flush", 128'(mul_bisonn_valid_o), 128'd0);
            if (resp_valid_o) begin
                resp_rec_t r;
                r.edge_n = cyc + 1;
                r.data   = resp_data_o;
                r.tag    = resp_tag_o;
                rq.push_back(r);
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t,
                        output int acc);
        int n;
        req_valid_i = 1'b1;
        req_rs1_i   = a;
        req_rs2_i   = b;
        req_tag_i   = t;
        n = 0;
        while (!req_ready_o && n < 40) begin
            cyc_wait(1);
            n++;
        end
        if (n >= 40) chk("push_timeout", 128'd1, 128'd0);
        cyc_wait(1);
        acc         = cyc;
        req_valid_i = 1'b0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        req_tag_i   = '0;
    endtask

    task automatic clear_q();
        gq.delete();
        rq.delete();
    endtask

    // Check a response sequence: tags, products and optional back-to-back timing.
    task automatic chk_resps(input string nm, input logic [3:0] tags[], input logic [63:0] data[],
                             input int first_edge, input int n_consec);
        chk({nm, "_nresp"}, 128'(rq.size()), 128'(tags.size()));
        for (int i = 0; i < tags.size() && i < rq.size(); i++) begin
            chk({nm, "_tag"}, 128'(rq[i].tag), 128'(tags[i]));
            chk({nm, "_data"}, 128'(rq[i].data), 128'(data[i]));
            if (i == 0 && first_edge >= 0)
                chk({nm, "_first_edge"}, 128'(rq[0].edge_n), 128'(first_edge));
            if (i > 0 && i < n_consec)
                chk({nm, "_consec"}, 128'(rq[i].edge_n), 128'(rq[0].edge_n + i));
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int st0;
        logic [3:0]  tg[];
        logic [63:0] dt[];

        rst_i            = 1'b1;
        req_valid_i      = 1'b0;
        req_rs1_i        = '0;
        req_rs2_i        = '0;
        req_tag_i        = '0;
        core_mul_valid_i = 1'b0;
        flush_mul_i      = 1'b0;
        cyc_wait(3);
        chk("rst_ready", 128'(req_ready_o), 128'd1);
        chk("rst_resp_valid", 128'(resp_valid_o), 128'd0);
        chk("rst_mul_valid", 128'(mul_bisonn_valid_o), 128'd0);
        chk("rst_stall", 128'(core_mul_stall_o), 128'd0);
        chk("rst_resp_data", 128'(resp_data_o), 128'd0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        cyc_wait(1);
        chk("post_rst_ready", 128'(req_ready_o), 128'd1);

        // Idle core: 3*5, grant one cycle after accept, response at E+3.
        clear_q();
        push(64'd3, 64'd5, 4'd1, acc);
        cyc_wait(5);
        chk("t2_ngrant", 128'(gq.size()), 128'd1);
        if (gq.size() > 0) begin
            chk("t2_grant_edge", 128'(gq[0].edge_n), 128'(acc + 1));
            chk("t2_grant_ops", {gq[0].a, gq[0].b}, {64'd3, 64'd5});
        end
        tg = '{4'd1};
        dt = '{64'd15};
        chk_resps("t2", tg, dt, acc + 3, 1);

        // Busy core: eight deferred cycles, then one stalling grant.
        clear_q();
        core_mul_valid_i = 1'b1;
        st0 = n_stall;
        push(64'd2, 64'd2, 4'd4, acc);
        cyc_wait(12);
        chk("t3_ngrant", 128'(gq.size()), 128'd1);
        if (gq.size() > 0) begin
            chk("t3_grant_edge", 128'(gq[0].edge_n), 128'(acc + 9));
            chk("t3_grant_stall", 128'(gq[0].stall), 128'd1);
        end
        chk("t3_stall_cycles", 128'(n_stall - st0), 128'd1);
        tg = '{4'd4};
        dt = '{64'd4};
        chk_resps("t3", tg, dt, acc + 11, 1);
        clear_q();
        push(64'd6, 64'd7, 4'd5, acc2);
        cyc_wait(12);
        chk("t3b_ngrant", 128'(gq.size()), 128'd1);
        if (gq.size() > 0) chk("t3b_grant_edge", 128'(gq[0].edge_n), 128'(acc2 + 9));
        tg = '{4'd5};
        dt = '{64'd42};
        chk_resps("t3b", tg, dt, acc2 + 11, 1);
        core_mul_valid_i = 1'b0;
        cyc_wait(2);

        // Flush in G+1 kills tag 2; it is reissued ahead of tag 3.
        clear_q();
        push(64'd7, 64'd9, 4'd2, acc);
        push(64'd4, 64'd5, 4'd3, acc2);
        flush_mul_i = 1'b1;
        cyc_wait(1);
        flush_mul_i = 1'b0;
        cyc_wait(6);
        chk("t4_ngrant", 128'(gq.size()), 128'd3);
        if (gq.size() == 3) begin
            chk("t4_reissue_edge", 128'(gq[1].edge_n), 128'(acc + 3));
            chk("t4_reissue_ops", {gq[1].a, gq[1].b}, {64'd7, 64'd9});
            chk("t4_next_ops", {gq[2].a, gq[2].b}, {64'd4, 64'd5});
        end
        tg = '{4'd2, 4'd3};
        dt = '{64'd63, 64'd20};
        chk_resps("t4", tg, dt, acc + 5, 2);

        // Busy core fills the buffer; fifth request waits for a free slot.
        clear_q();
        core_mul_valid_i = 1'b1;
        push(64'd1, 64'd1, 4'd0, acc);
        push(64'd2, 64'd3, 4'd1, acc);
        push(64'd100, 64'd200, 4'd2, acc);
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd3, acc);
        req_valid_i = 1'b1;
        req_rs1_i   = 64'd10;
        req_rs2_i   = 64'd11;
        req_tag_i   = 4'd9;
        #1;
        chk("t5_full_not_ready", 128'(req_ready_o), 128'd0);
        chk("t5_no_grant_busy", 128'(gq.size()), 128'd0);
        core_mul_valid_i = 1'b0;
        push(64'd10, 64'd11, 4'd9, acc2);
        cyc_wait(8);
        tg = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9};
        dt = '{64'd1, 64'd6, 64'd20000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd110};
        chk_resps("t5", tg, dt, -1, 4);

        // Four queued, then released: back-to-back grants and responses.
        clear_q();
        core_mul_valid_i = 1'b1;
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, acc);
        push(64'h1_0000_0000, 64'h1_0000_0000, 4'd11, acc);
        push(64'hDEAD_BEEF, 64'h10, 4'd12, acc);
        push(64'h1_2345_6789, 64'h1000, 4'd13, acc);
        core_mul_valid_i = 1'b0;
        cyc_wait(8);
        chk("t6_ngrant", 128'(gq.size()), 128'd4);
        for (int i = 1; i < gq.size(); i++)
            chk("t6_grant_consec", 128'(gq[i].edge_n), 128'(gq[0].edge_n + i));
        tg = '{4'd10, 4'd11, 4'd12, 4'd13};
        dt = '{64'd1, 64'd0, 64'hD_EADB_EEF0, 64'h1234_5678_9000};
        chk_resps("t6", tg, dt, acc + 3, 4);

        // Reset in G+1 with ops in flight: nothing comes back afterwards.
        clear_q();
        push(64'd5, 64'd5, 4'd7, acc);
        push(64'd6, 64'd6, 4'd8, acc2);
        rst_i = 1'b1;
        cyc_wait(1);
        rst_i = 1'b0;
        clear_q();
        chk("t7_ready_after_rst", 128'(req_ready_o), 128'd1);
        cyc_wait(6);
        chk("t7_no_resp", 128'(rq.size()), 128'd0);
        chk("t7_no_grant", 128'(gq.size()), 128'd0);
        chk("t7_ready_idle", 128'(req_ready_o), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
